// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request record used by both sources and the FIFO.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the pipeline/long-latency units and the writeback arbiter.
// master = pipeline side (drives requests and decode addresses),
// slave  = arbiter side (drives ready, stall, busy flags and the write port).
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  a_valid;
  logic [REG_ADDR_W-1:0] a_addr;
  logic [XLEN-1:0]       a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [REG_ADDR_W-1:0] b_addr;
  logic [XLEN-1:0]       b_data;
  logic                  stall_req;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic [CW-1:0]         count;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rs1_addr, rs2_addr,
    input  b_ready, stall_req, rs1_busy, rs2_busy, wr_en, wr_addr, wr_data, count
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, rs1_addr, rs2_addr,
    output b_ready, stall_req, rs1_busy, rs2_busy, wr_en, wr_addr, wr_data, count
  );

endinterface

// File: rtl/wb_fifo.sv
// Small register-based FIFO for deferred writebacks. Every slot's valid bit and
// address are exported so the arbiter can do a parallel busy compare.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_req_t                       push_req,
  input  logic                          pop,
  output wb_req_t                       head,
  output logic [CW-1:0]                 count,
  output logic                          full,
  output logic                          empty,
  output logic                          empty_next,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH*REG_ADDR_W-1:0]   entry_addr
);

  wb_req_t          mem_reg [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  // Occupancy after this edge; the arbiter uses it to know when the queue drains.
  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CW'(1);
    else if (!push && pop)
      count_next = count_reg - CW'(1);
  end

  // Pointer, occupancy and slot-valid bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      if (push) begin
        valid_reg[wr_ptr_reg] <= 1'b1;
        wr_ptr_reg            <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg            <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Entry storage; contents are only meaningful where the slot-valid bit is set.
  always_ff @(posedge clk) begin
    if (push)
      mem_reg[wr_ptr_reg] <= push_req;
  end

  assign head        = mem_reg[rd_ptr_reg];
  assign count       = count_reg;
  assign full        = (count_reg == CW'(DEPTH));
  assign empty       = (count_reg == '0);
  assign empty_next  = (count_next == '0);
  assign entry_valid = valid_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr
      assign entry_addr[gi*REG_ADDR_W +: REG_ADDR_W] = mem_reg[gi].addr;
    end
  endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the in-order pipeline (A, always
// first) and a FIFO of long-latency results (B) drained into idle cycles.
// Also produces decode busy flags and a starvation stall request.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  wb_req_t                     head;
  wb_req_t                     push_req;
  logic                        full;
  logic                        empty;
  logic                        empty_next;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH*REG_ADDR_W-1:0] entry_addr;
  logic                        a_win;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [WW-1:0]               wait_reg;
  logic [WW-1:0]               wait_next;
  logic                        stall_reg;
  logic [DEPTH-1:0]            match1;
  logic [DEPTH-1:0]            match2;

  // A writes to x0 are dropped so the port falls through to the FIFO head.
  assign a_win     = bus.a_valid && (bus.a_addr != '0);
  assign fifo_pop  = !rst && !a_win && !empty;
  // x0 results complete their handshake but are never queued.
  assign fifo_push = !rst && bus.b_valid && !full && (bus.b_addr != '0);
  assign push_req  = '{addr: bus.b_addr, data: bus.b_data};

  assign bus.b_ready   = !rst && !full;
  assign bus.wr_en     = !rst && (a_win || !empty);
  assign bus.wr_addr   = a_win ? bus.a_addr : head.addr;
  assign bus.wr_data   = a_win ? bus.a_data : head.data;
  assign bus.stall_req = stall_reg;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_req    (push_req),
    .pop         (fifo_pop),
    .head        (head),
    .count       (bus.count),
    .full        (full),
    .empty       (empty),
    .empty_next  (empty_next),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Count consecutive blocked cycles of a non-empty queue, saturating.
  always_comb begin
    wait_next = wait_reg;
    if (empty || fifo_pop)
      wait_next = '0;
    else if (wait_reg != WAIT_MAX)
      wait_next = wait_reg + WW'(1);
  end

  // Stall holds from the point of starvation until the queue has fully drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_reg  <= '0;
      stall_reg <= 1'b0;
    end else begin
      wait_reg <= wait_next;
      if (empty_next)
        stall_reg <= 1'b0;
      else if (wait_next == WAIT_MAX)
        stall_reg <= 1'b1;
    end
  end

  // Per-slot compare; the entry being popped still reads as busy this cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign match1[gi] = entry_valid[gi] &&
                          (entry_addr[gi*REG_ADDR_W +: REG_ADDR_W] == bus.rs1_addr);
      assign match2[gi] = entry_valid[gi] &&
                          (entry_addr[gi*REG_ADDR_W +: REG_ADDR_W] == bus.rs2_addr);
    end
  endgenerate

  assign bus.rs1_busy = (bus.rs1_addr != '0) && (|match1);
  assign bus.rs2_busy = (bus.rs2_addr != '0) && (|match2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, a queue-based reference
// model checked every cycle, and randomized traffic with occasional resets.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    int          e_cnt;
    logic        e_stall;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: the pending queue, blocked-cycle counter, stall flag.
  wb_req_t q[$];
  int      m_wait  = 0;
  bit      m_stall = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cyc=%0d %s actual=%0h expected=%0h", cyc, name, act, exp);
    end
  endfunction

  function automatic bit in_q(logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void add(logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic [4:0] r1, logic [4:0] r2,
                              logic en, logic [4:0] ea, logic [31:0] ed,
                              logic rdy, int cnt, logic st, logic b1, logic b2);
    vec_t v;
    v.s = '{rst: 1'b0, a_valid: av, a_addr: aa, a_data: ad, b_valid: bv,
            b_addr: ba, b_data: bd, rs1: r1, rs2: r2};
    v.e_en = en; v.e_addr = ea; v.e_data = ed; v.e_rdy = rdy;
    v.e_cnt = cnt; v.e_stall = st; v.e_b1 = b1; v.e_b2 = b2;
    tbl.push_back(v);
  endfunction

  // One clock: drive, check against model (and table row if given), advance model.
  task automatic step(input stim_t s, input bit has_row, input vec_t v);
    bit          a_win, was_empty, popped, accepted;
    logic        e_rdy, e_en, e_b1, e_b2;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    rst          = s.rst;
    bus.a_valid  = s.a_valid;
    bus.a_addr   = s.a_addr;
    bus.a_data   = s.a_data;
    bus.b_valid  = s.b_valid;
    bus.b_addr   = s.b_addr;
    bus.b_data   = s.b_data;
    bus.rs1_addr = s.rs1;
    bus.rs2_addr = s.rs2;
    assert (s.rst || !(s.a_valid && in_q(s.a_addr)))
      else $error("bench issued A to a register with a pending write");
    @(negedge clk);
    a_win  = s.a_valid && (s.a_addr != 5'd0);
    e_rdy  = !s.rst && (q.size() < DEPTH);
    e_en   = !s.rst && (a_win || q.size() > 0);
    e_addr = a_win ? s.a_addr : (q.size() > 0 ? q[0].addr : 5'd0);
    e_data = a_win ? s.a_data : (q.size() > 0 ? q[0].data : 32'd0);
    e_b1   = in_q(s.rs1);
    e_b2   = in_q(s.rs2);
    chk("b_ready", 32'(bus.b_ready), 32'(e_rdy));
    chk("wr_en", 32'(bus.wr_en), 32'(e_en));
    if (e_en) begin
      chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
      chk("wr_data", bus.wr_data, e_data);
    end
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("stall_req", 32'(bus.stall_req), 32'(m_stall));
    chk("rs1_busy", 32'(bus.rs1_busy), 32'(e_b1));
    chk("rs2_busy", 32'(bus.rs2_busy), 32'(e_b2));
    if (has_row) begin
      chk("row_wr_en", 32'(bus.wr_en), 32'(v.e_en));
      if (v.e_en) begin
        chk("row_wr_addr", 32'(bus.wr_addr), 32'(v.e_addr));
        chk("row_wr_data", bus.wr_data, v.e_data);
      end
      chk("row_b_ready", 32'(bus.b_ready), 32'(v.e_rdy));
      chk("row_count", 32'(bus.count), 32'(v.e_cnt));
      chk("row_stall", 32'(bus.stall_req), 32'(v.e_stall));
      chk("row_rs1_busy", 32'(bus.rs1_busy), 32'(v.e_b1));
      chk("row_rs2_busy", 32'(bus.rs2_busy), 32'(v.e_b2));
    end
    $display("cyc=%0d rst=%0b a=%0b/x%0d b=%0b/x%0d wr=%0b/x%0d/%0h cnt=%0d stall=%0b",
             cyc, s.rst, s.a_valid, s.a_addr, s.b_valid, s.b_addr,
             bus.wr_en, bus.wr_addr, bus.wr_data, bus.count, bus.stall_req);
    if (s.rst) begin
      q.delete();
      m_wait  = 0;
      m_stall = 1'b0;
    end else begin
      was_empty = (q.size() == 0);
      popped    = !a_win && !was_empty;
      accepted  = s.b_valid && (q.size() < DEPTH);
      if (popped) void'(q.pop_front());
      if (accepted && s.b_addr != 5'd0)
        q.push_back('{addr: s.b_addr, data: s.b_data});
      if (was_empty || popped) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (q.size() == 0) m_stall = 1'b0;
      else if (m_wait == MAX_WAIT) m_stall = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic stim_t idle(logic [4:0] r1, logic [4:0] r2);
    return '{rst: 1'b0, a_valid: 1'b0, a_addr: 5'd0, a_data: 32'd0, b_valid: 1'b0,
             b_addr: 5'd0, b_data: 32'd0, rs1: r1, rs2: r2};
  endfunction

  initial begin
    vec_t  none;
    stim_t s;
    none = '{s: '0, e_en: 0, e_addr: 0, e_data: 0, e_rdy: 0, e_cnt: 0,
             e_stall: 0, e_b1: 0, e_b2: 0};

    // B only: x5 then x6, writes 1 and 2 cycles later; x5 busy through its write.
    add(0,0,0,        1,5,32'h1111, 5,0,  0,0,0,            1,0,0, 0,0);
    add(0,0,0,        1,6,32'h2222, 5,6,  1,5,32'h1111,     1,1,0, 1,0);
    add(0,0,0,        0,0,0,        5,6,  1,6,32'h2222,     1,1,0, 0,1);
    add(0,0,0,        0,0,0,        5,6,  0,0,0,            1,0,0, 0,0);
    // Priority: A holds the port two cycles, queued x7 goes on the third.
    add(0,0,0,        1,7,32'hAAAA, 7,0,  0,0,0,            1,0,0, 0,0);
    add(1,3,32'h33,   0,0,0,        7,3,  1,3,32'h33,       1,1,0, 1,0);
    add(1,3,32'h33,   0,0,0,        7,0,  1,3,32'h33,       1,1,0, 1,0);
    add(0,0,0,        0,0,0,        7,0,  1,7,32'hAAAA,     1,1,0, 1,0);
    add(0,0,0,        0,0,0,        7,0,  0,0,0,            1,0,0, 0,0);
    // Fill under continuous A; starvation raises stall; 5th push refused.
    add(1,1,32'h101,  1,8,32'h8,    8,0,  1,1,32'h101,      1,0,0, 0,0);
    add(1,1,32'h101,  1,9,32'h9,    8,9,  1,1,32'h101,      1,1,0, 1,0);
    add(1,1,32'h101,  1,10,32'hA,   8,9,  1,1,32'h101,      1,2,0, 1,1);
    add(1,1,32'h101,  1,11,32'hB,   10,11,1,1,32'h101,      1,3,0, 1,0);
    add(1,1,32'h101,  1,12,32'hC,   11,12,1,1,32'h101,      0,4,1, 1,0);
    add(1,1,32'h101,  0,0,0,        12,11,1,1,32'h101,      0,4,1, 0,1);
    // Drain at one per cycle, stall clears as the queue empties.
    add(0,0,0,        0,0,0,        8,0,  1,8,32'h8,        0,4,1, 1,0);
    add(0,0,0,        0,0,0,        8,9,  1,9,32'h9,        1,3,1, 0,1);
    add(0,0,0,        0,0,0,        10,0, 1,10,32'hA,       1,2,1, 1,0);
    add(0,0,0,        0,0,0,        11,0, 1,11,32'hB,       1,1,1, 1,0);
    add(0,0,0,        0,0,0,        11,0, 0,0,0,            1,0,0, 0,0);
    // x0 handling on both sources and on the busy lookup.
    add(0,0,0,        1,0,32'hDEAD, 0,0,  0,0,0,            1,0,0, 0,0);
    add(0,0,0,        0,0,0,        0,0,  0,0,0,            1,0,0, 0,0);
    add(0,0,0,        1,13,32'hD,   13,0, 0,0,0,            1,0,0, 0,0);
    add(1,0,32'hFFFF, 0,0,0,        0,13, 1,13,32'hD,       1,1,0, 0,1);
    add(0,0,0,        0,0,0,        13,0, 0,0,0,            1,0,0, 0,0);

    // Reset with both sources requesting: ready and write enable held low.
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h5;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h6;
    bus.rs1_addr = 5'd4; bus.rs2_addr = 5'd0;
    @(negedge clk);
    chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    @(posedge clk);
    #1;
    s = '{rst: 1'b1, a_valid: 1'b1, a_addr: 5'd3, a_data: 32'h5, b_valid: 1'b1,
          b_addr: 5'd4, b_data: 32'h6, rs1: 5'd4, rs2: 5'd0};
    step(s, 1'b0, none);
    step(s, 1'b0, none);

    foreach (tbl[i]) step(tbl[i].s, 1'b1, tbl[i]);

    // Mid-operation reset discards queued entries without writing them.
    s = idle(5'd20, 5'd21); s.b_valid = 1'b1; s.b_addr = 5'd20; s.b_data = 32'h20;
    s.a_valid = 1'b1; s.a_addr = 5'd2; s.a_data = 32'h2;
    step(s, 1'b0, none);
    s.b_addr = 5'd21; s.b_data = 32'h21;
    step(s, 1'b0, none);
    s = idle(5'd20, 5'd21); s.rst = 1'b1; s.a_valid = 1'b1; s.a_addr = 5'd4;
    step(s, 1'b0, none);
    step(idle(5'd20, 5'd21), 1'b0, none);
    step(idle(5'd20, 5'd21), 1'b0, none);

    // Randomized traffic against the model; A mostly honours stall and never
    // targets a pending register.
    for (int n = 0; n < 800; n++) begin
      s.rst     = ($urandom_range(0, 99) == 0);
      s.a_valid = m_stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      s.a_addr  = 5'($urandom_range(0, 31));
      if (in_q(s.a_addr)) s.a_addr = 5'd0;
      s.a_data  = $urandom;
      s.b_valid = ($urandom_range(0, 1) == 1);
      s.b_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.b_data  = $urandom;
      s.rs1     = (q.size() > 0 && $urandom_range(0, 1) == 1) ?
                  q[$urandom_range(0, q.size() - 1)].addr : 5'($urandom_range(0, 31));
      s.rs2     = 5'($urandom_range(0, 31));
      step(s, 1'b0, none);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
